// File: rtl/spmv_csr_engine.sv
// Sparse matrix-vector multiply over CSR storage.
// Load port fills value/column/rowptr/x memories, then one start computes
// y[r] = sum(value[k] * x[col[k]]) per row and hands each row out on a
// valid/ready port. Memories are synchronous-read and are never reset.
//
// state | meaning
// IDLE  | waiting for start, load port open
// PTR   | two cycles: read rowptr[r], rowptr[r+1], then classify the row
// MAC   | issue one nonzero per cycle through a 2-stage read pipeline
// EMIT  | hold out_valid until out_ready
// FIN   | one-cycle done pulse
module spmv_csr_engine #(
    parameter int DATA_W    = 32,
    parameter int ACC_W     = 64,
    parameter int NNZ_DEPTH = 1024,
    parameter int ROW_DEPTH = 256,
    parameter int COL_DEPTH = 256,
    parameter int SATURATE  = 0,
    parameter int AW        = $clog2(NNZ_DEPTH),
    parameter int RW        = $clog2(ROW_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_we,
    input  logic [1:0]        in_sel,
    input  logic [AW-1:0]     in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              start,
    input  logic [RW-1:0]     n_rows,
    input  logic [AW-1:0]     n_cols,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [RW-1:0]     out_row,
    output logic              out_zero,
    output logic              done,
    output logic              err
);
    localparam int XW = $clog2(COL_DEPTH);
    localparam logic [AW:0] NNZ_L = (AW+1)'(NNZ_DEPTH);
    localparam logic [AW:0] RP_L  = (AW+1)'(ROW_DEPTH + 1);
    localparam logic [AW:0] X_L   = (AW+1)'(COL_DEPTH);
    localparam logic [RW-1:0] ROW_L = RW'(ROW_DEPTH);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PTR, S_MAC, S_EMIT, S_FIN} state_t;

    logic [DATA_W-1:0] val_mem [NNZ_DEPTH];
    logic [AW-1:0]     col_mem [NNZ_DEPTH];
    logic [AW-1:0]     rp_mem  [ROW_DEPTH+1];
    logic [DATA_W-1:0] x_mem   [COL_DEPTH];

    state_t            state_q, state_d;
    logic [RW-1:0]     r_q, r_d, nrows_q, nrows_d;
    logic [AW-1:0]     ncols_q, ncols_d;
    logic [AW:0]       k_q, k_d, hi_q, hi_d;
    logic              err_q, err_d, ph_q, ph_d, zero_q, zero_d;
    logic              s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [ACC_W-1:0]  acc_q, acc_d;

    logic [DATA_W-1:0] val_rd_q, val_dly_q, x_rd_q;
    logic [AW-1:0]     col_rd_q, rp_lo_q, rp_hi_q;

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext, sum, acc_next;
    logic                ovf;

    // Load port: only while idle and only to in-range addresses.
    always_ff @(posedge clk) begin
        if (in_we && !busy) begin
            case (in_sel)
                2'b00: if ({1'b0, in_addr} < NNZ_L) val_mem[in_addr] <= in_data;
                2'b01: if ({1'b0, in_addr} < NNZ_L) col_mem[in_addr] <= in_data[AW-1:0];
                2'b10: if ({1'b0, in_addr} < RP_L)  rp_mem[in_addr[RW-1:0]] <= in_data[AW-1:0];
                2'b11: if ({1'b0, in_addr} < X_L)   x_mem[in_addr[XW-1:0]] <= in_data;
                default: ;
            endcase
        end
    end

    // Synchronous reads: stage 1 value/col, stage 2 x[col]; rowptr pair follows r.
    always_ff @(posedge clk) begin
        val_rd_q  <= val_mem[k_q[AW-1:0]];
        col_rd_q  <= col_mem[k_q[AW-1:0]];
        x_rd_q    <= x_mem[col_rd_q[XW-1:0]];
        val_dly_q <= val_rd_q;
        rp_lo_q   <= rp_mem[r_q];
        rp_hi_q   <= rp_mem[r_q + RW'(1)];
    end

    // Signed product, sign-extended, with optional saturating add.
    always_comb begin
        prod     = $signed({{DATA_W{val_dly_q[DATA_W-1]}}, val_dly_q})
                 * $signed({{DATA_W{x_rd_q[DATA_W-1]}}, x_rd_q});
        prod_ext = ACC_W'($signed(prod));
        sum      = acc_q + prod_ext;
        ovf      = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        acc_next = sum;
        if (SATURATE != 0 && ovf) acc_next = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        nrows_d = nrows_q;
        ncols_d = ncols_q;
        k_d     = k_q;
        hi_d    = hi_q;
        err_d   = err_q;
        ph_d    = ph_q;
        zero_d  = zero_q;
        acc_d   = acc_q;
        s1_v_d  = 1'b0;
        s2_v_d  = 1'b0;
        if (s2_v_q) acc_d = acc_next;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nrows_d = n_rows;
                    ncols_d = n_cols;
                    r_d     = '0;
                    err_d   = 1'b0;
                    ph_d    = 1'b0;
                    state_d = (n_rows == '0) ? S_FIN : S_PTR;
                end
            end
            S_PTR: begin
                if (!ph_q) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d  = 1'b0;
                    acc_d = '0;
                    if (rp_hi_q < rp_lo_q || {1'b0, rp_hi_q} > NNZ_L || r_q >= ROW_L) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (rp_hi_q == rp_lo_q) begin
                        zero_d  = 1'b1;
                        state_d = S_EMIT;
                    end else begin
                        zero_d  = 1'b0;
                        k_d     = {1'b0, rp_lo_q};
                        hi_d    = {1'b0, rp_hi_q};
                        state_d = S_MAC;
                    end
                end
            end
            S_MAC: begin
                if (k_q != hi_q) begin
                    s1_v_d = 1'b1;
                    k_d    = k_q + 1'b1;
                end
                s2_v_d = s1_v_q;
                if (s1_v_q && (col_rd_q >= ncols_q || {1'b0, col_rd_q} >= X_L)) begin
                    err_d   = 1'b1;
                    s1_v_d  = 1'b0;
                    s2_v_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (k_q == hi_q && !s1_v_q) begin
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    r_d     = r_q + RW'(1);
                    ph_d    = 1'b0;
                    state_d = (r_q + RW'(1) == nrows_q) ? S_FIN : S_PTR;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            nrows_q <= '0;
            ncols_q <= '0;
            k_q     <= '0;
            hi_q    <= '0;
            err_q   <= 1'b0;
            ph_q    <= 1'b0;
            zero_q  <= 1'b0;
            acc_q   <= '0;
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            nrows_q <= nrows_d;
            ncols_q <= ncols_d;
            k_q     <= k_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
            ph_q    <= ph_d;
            zero_q  <= zero_d;
            acc_q   <= acc_d;
            s1_v_q  <= s1_v_d;
            s2_v_q  <= s2_v_d;
        end
    end

    // Outputs are gated by state so reset and idle present all zeros.
    always_comb begin
        busy      = (state_q == S_PTR) || (state_q == S_MAC) || (state_q == S_EMIT);
        out_valid = (state_q == S_EMIT);
        out_data  = out_valid ? acc_q : '0;
        out_row   = out_valid ? r_q : '0;
        out_zero  = out_valid && zero_q;
        done      = (state_q == S_FIN);
        err       = err_q;
    end
endmodule

// File: tb/tb_spmv_csr_engine.sv
// Bench for spmv_csr_engine: one modulo and one saturating instance share
// all inputs; a CSR reference model computes every row result.
module tb_spmv_csr_engine;
    localparam int DW = 32, ACW = 64, AW = 10, RW = 9;

    logic clk = 1'b0, reset = 1'b0;
    logic in_we = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [1:0] in_sel = '0;
    logic [AW-1:0] in_addr = '0, n_cols = '0;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] n_rows = '0;
    logic busy0, out_valid0, out_zero0, done0, err0;
    logic busy1, out_valid1, out_zero1, done1, err1;
    logic [ACW-1:0] out_data0, out_data1;
    logic [RW-1:0] out_row0, out_row1;

    int n_tests = 0, n_fail = 0;

    logic [31:0] m_val [1024];
    logic [9:0]  m_col [1024];
    logic [9:0]  m_rp  [257];
    logic [31:0] m_x   [1024];

    always #5 clk = ~clk;

    spmv_csr_engine #(.SATURATE(0)) u_mod (
        .clk(clk), .reset(reset), .in_we(in_we), .in_sel(in_sel), .in_addr(in_addr),
        .in_data(in_data), .start(start), .n_rows(n_rows), .n_cols(n_cols),
        .busy(busy0), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_row(out_row0), .out_zero(out_zero0), .done(done0), .err(err0));

    spmv_csr_engine #(.SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .in_we(in_we), .in_sel(in_sel), .in_addr(in_addr),
        .in_data(in_data), .start(start), .n_rows(n_rows), .n_cols(n_cols),
        .busy(busy1), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_row(out_row1), .out_zero(out_zero1), .done(done1), .err(err1));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural row result straight from the CSR definition.
    function automatic logic [63:0] ref_row(input int r, input bit sat);
        longint acc = 0;
        logic signed [65:0] a = '0;
        logic signed [65:0] smax = (66'sd1 <<< 63) - 66'sd1;
        logic signed [65:0] smin = -(66'sd1 <<< 63);
        for (int k = int'(m_rp[r]); k < int'(m_rp[r+1]); k++) begin
            longint p = longint'($signed(m_val[k])) * longint'($signed(m_x[m_col[k]]));
            acc += p;
            a = a + 66'(p);
            if (a > smax) a = smax;
            if (a < smin) a = smin;
        end
        return sat ? a[63:0] : 64'(acc);
    endfunction

    // Write through the load port; the mirror follows the in-range rules.
    task automatic wr(input int sel, input int addr, input logic [31:0] data);
        @(negedge clk);
        in_we = 1'b1; in_sel = 2'(sel); in_addr = AW'(addr); in_data = data;
        @(posedge clk);
        #1 in_we = 1'b0;
        case (sel)
            0: if (addr < 1024) m_val[addr] = data;
            1: if (addr < 1024) m_col[addr] = data[9:0];
            2: if (addr <= 256) m_rp[addr] = data[9:0];
            3: if (addr < 256)  m_x[addr] = data;
            default: ;
        endcase
    endtask

    task automatic pulse_start(input int nr, input int nc);
        @(negedge clk);
        n_rows = RW'(nr); n_cols = AW'(nc); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Full run with handshakes; optional ready stall and a busy-time poke.
    task automatic run(input int nr, input int nc, input int hold_row, input int hold_n, input bit poke);
        int cnt, k;
        logic [63:0] snap;
        pulse_start(nr, nc);
        chk("err_cleared_on_start", err0, 0);
        for (int r = 0; r < nr; r++) begin
            k = int'(m_rp[r+1]) - int'(m_rp[r]);
            cnt = 0;
            while (!out_valid0 && cnt < 60) begin
                if (poke && r == 0 && cnt == 0) begin
                    in_we = 1'b1; in_sel = 2'b11; in_addr = '0; in_data = $urandom();
                    start = 1'b1; n_rows = '0;
                end else if (poke && r == 0 && cnt == 1) begin
                    in_we = 1'b0; start = 1'b0;
                end
                @(negedge clk);
                cnt++;
            end
            in_we = 1'b0; start = 1'b0;
            if (!out_valid0) begin
                chk("out_valid_timeout", 0, 1);
                return;
            end
            chk("latency_within_k_plus_4", cnt <= k + 4, 1);
            chk("out_row", out_row0, r);
            chk("out_zero", out_zero0, k == 0);
            chk("out_data_mod", out_data0, ref_row(r, 0));
            chk("out_data_sat", out_data1, ref_row(r, 1));
            chk("busy_during_emit", busy0, 1);
            if (r == hold_row) begin
                snap = out_data0;
                repeat (hold_n) begin
                    @(negedge clk);
                    chk("stall_valid", out_valid0, 1);
                    chk("stall_data", out_data0, snap);
                    chk("stall_row", out_row0, r);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (r == nr - 1) begin
                chk("done_pulse", done0, 1);
                chk("busy_low_at_done", busy0, 0);
            end else begin
                chk("no_early_done", done0, 0);
            end
        end
        @(negedge clk);
        chk("done_single_cycle", done0, 0);
    endtask

    task automatic load_csr(input int nrows, input int nnz[], input int ncols, input bit big);
        int p = 0;
        wr(2, 0, 0);
        for (int r = 0; r < nrows; r++) begin
            for (int j = 0; j < nnz[r]; j++) begin
                logic [31:0] v;
                v = (big && $urandom_range(0, 3) == 0) ? $urandom() : 32'(int'($urandom_range(0, 200)) - 100);
                wr(0, p, v);
                wr(1, p, $urandom_range(0, ncols - 1));
                p++;
            end
            wr(2, r + 1, p);
        end
        for (int c = 0; c < ncols; c++) wr(3, c, (big && $urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 50)));
    endtask

    initial begin
        int seen;
        // Reset state
        #12;
        chk("rst_busy", busy0, 0);
        chk("rst_valid", out_valid0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_zero", out_zero0, 0);
        chk("rst_data", out_data0, 0);
        chk("rst_row", out_row0, 0);
        @(negedge clk); reset = 1'b1;

        // 2x2 identity
        wr(0, 0, 1); wr(0, 1, 1); wr(1, 0, 0); wr(1, 1, 1);
        wr(2, 0, 0); wr(2, 1, 1); wr(2, 2, 2); wr(3, 0, 5); wr(3, 1, 7);
        run(2, 2, -1, 0, 0);

        // Empty row plus cancelling row, with a 10-cycle stall on row 0
        wr(2, 0, 0); wr(2, 1, 0); wr(2, 2, 2);
        wr(0, 0, 3); wr(0, 1, 32'hFFFF_FFFE); wr(1, 0, 0); wr(1, 1, 1);
        wr(3, 0, 4); wr(3, 1, 6);
        run(2, 2, 0, 10, 0);

        // Positive and negative saturation
        for (int k = 0; k < 5; k++) begin wr(0, k, 32'h7FFF_FFFF); wr(1, k, 0); end
        for (int k = 5; k < 9; k++) begin wr(0, k, 32'h8000_0000); wr(1, k, 0); end
        wr(2, 0, 0); wr(2, 1, 5); wr(2, 2, 9); wr(3, 0, 32'h7FFF_FFFF);
        run(2, 1, -1, 0, 0);
        chk("sat_max_model", ref_row(0, 1), 64'h7FFF_FFFF_FFFF_FFFF);

        // Out-of-range x write must not alias onto x[0]
        wr(3, 256, 32'd123);
        run(2, 1, -1, 0, 0);

        // n_rows == 0: done next cycle, no results
        pulse_start(0, 1);
        chk("zero_rows_done", done0, 1);
        chk("zero_rows_no_valid", out_valid0, 0);
        @(negedge clk);
        chk("zero_rows_done_once", done0, 0);

        // Column index out of range
        wr(0, 0, 1); wr(1, 0, 9); wr(2, 0, 0); wr(2, 1, 1);
        pulse_start(1, 4);
        seen = 0;
        for (int c = 0; c < 20 && !err0; c++) begin
            if (done0) seen = 1;
            @(negedge clk);
        end
        chk("col_err_set", err0, 1);
        chk("col_err_busy", busy0, 0);
        chk("col_err_valid", out_valid0, 0);
        repeat (5) begin if (done0 || out_valid0) seen = 1; @(negedge clk); end
        chk("col_err_no_done", seen, 0);
        chk("col_err_sticky", err0, 1);
        wr(1, 0, 2);
        run(1, 4, -1, 0, 0);
        chk("err_stays_clear", err0, 0);

        // Randomized CSR matrices with stalls and busy-time pokes
        for (int it = 0; it < 8; it++) begin
            int nr, nc;
            int nnz[];
            nr = $urandom_range(1, 5);
            nc = $urandom_range(1, 8);
            nnz = new[nr];
            foreach (nnz[i]) nnz[i] = $urandom_range(0, 4);
            load_csr(nr, nnz, nc, it >= 4);
            run(nr, nc, $urandom_range(0, nr - 1), $urandom_range(0, 3), it[0]);
        end

        // Reset during MAC of row 1
        wr(2, 0, 0); wr(2, 1, 1); wr(2, 2, 7); wr(2, 3, 8);
        for (int k = 0; k < 8; k++) begin wr(0, k, k + 1); wr(1, k, 0); end
        wr(3, 0, 3);
        pulse_start(3, 1);
        for (int c = 0; c < 30 && !out_valid0; c++) @(negedge clk);
        chk("pre_rst_row0", out_data0, ref_row(0, 0));
        out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy0, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_valid", out_valid0, 0);
        chk("mid_rst_data", out_data0, 0);
        chk("mid_rst_row", out_row0, 0);
        chk("mid_rst_done", done0, 0);
        chk("mid_rst_err", err0, 0);
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (50) begin @(negedge clk); if (out_valid0 || done0 || busy0) seen = 1; end
        chk("post_rst_quiet", seen, 0);
        run(3, 1, 2, 2, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spmv_csr_engine.md
SPMV_CSR_ENGINE -- requirements
Module: spmv_csr_engine

Interface
REQ-001 Parameter DATA_W, default 32, width of matrix values, x-vector entries and in_data.
REQ-002 Parameter ACC_W, default 64, accumulator and result width; ACC_W >= 2*DATA_W.
REQ-003 Parameter NNZ_DEPTH, default 1024, value/column memory depth; AW = $clog2(NNZ_DEPTH).
REQ-004 Parameter ROW_DEPTH, default 256, maximum rows; row-pointer memory holds ROW_DEPTH+1 entries; RW = $clog2(ROW_DEPTH+1).
REQ-005 Parameter COL_DEPTH, default 256, maximum columns (x-vector depth); NNZ_DEPTH >= ROW_DEPTH+1 and NNZ_DEPTH >= COL_DEPTH.
REQ-006 Parameter SATURATE, default 0: 0 = accumulate modulo 2^ACC_W; 1 = signed saturation at ACC_W.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 in_we  input  1  load-port write strobe.
REQ-010 in_sel  input  2  target: 00 value, 01 column index, 10 row pointer, 11 x vector.
REQ-011 in_addr  input  AW  load address.
REQ-012 in_data  input  DATA_W  load data; index and pointer targets use the low AW bits.
REQ-013 start  input  1  one-cycle pulse that begins a multiply.
REQ-014 n_rows  input  RW  row count, sampled on start.
REQ-015 n_cols  input  AW  column count, sampled on start.
REQ-016 busy  output  1  high from accepted start until done or err.
REQ-017 out_valid  output  1  result available.
REQ-018 out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-019 out_data  output  ACC_W  row dot product y[row].
REQ-020 out_row  output  RW  row index of out_data.
REQ-021 out_zero  output  1  row has no stored nonzeros (rowptr[r+1]==rowptr[r]).
REQ-022 done  output  1  one-cycle pulse after the last row is accepted.
REQ-023 err  output  1  sticky error flag, cleared by the next accepted start.

Function
REQ-024 Writes with in_we high, busy low and in-range address update the selected memory on that edge; out-of-range addresses and writes while busy are ignored.
REQ-025 start while busy is ignored; start with n_rows==0 pulses done on the next cycle, with no results.
REQ-026 FSM states: IDLE, PTR (read rowptr[r], rowptr[r+1]), MAC (one nonzero per cycle), EMIT (hold out_valid), FIN.
REQ-027 IDLE->PTR on accepted start; r=0; err cleared.
REQ-028 PTR->MAC when rowptr[r+1]>rowptr[r]; PTR->EMIT with out_data=0 and out_zero=1 when they are equal.
REQ-029 MAC issues one nonzero per cycle (value[k] times x[col[k]] with synchronous-read memories, 1-cycle read latency); after the last product the FSM enters EMIT. A row with k nonzeros presents out_valid no later than k+4 cycles after entering PTR.
REQ-030 Products are signed DATA_W x DATA_W, sign-extended to ACC_W; the accumulator clears at each row start.
REQ-031 SATURATE=1: the accumulator clamps at 2^(ACC_W-1)-1 or -2^(ACC_W-1) and does not wrap back.
REQ-032 EMIT: out_data, out_row and out_zero stay stable while out_valid is high and out_ready is low; on the handshake r increments; when r==n_rows the FSM goes to FIN, otherwise to PTR.
REQ-033 FIN: done pulses high for 1 cycle; busy drops in the same cycle; the FSM returns to IDLE.
REQ-034 Error cases: rowptr[r+1]<rowptr[r], rowptr>NNZ_DEPTH, or col[k]>=n_cols. Each sets err and clears busy and out_valid within 2 cycles, and the FSM returns to IDLE without a done pulse.
REQ-035 Memory contents persist across runs and are not cleared by reset.

Reset
REQ-036 reset low asynchronously forces IDLE, with busy, out_valid, out_zero, done and err at 0, and out_data and out_row at 0.
REQ-037 Reset asserted mid-run aborts the run; after release no result and no done is produced until a new start.

Verification
REQ-038 Load the 2x2 identity (value={1,1}, col={0,1}, rowptr={0,1,2}), x={5,7}, start with n_rows=2 and n_cols=2 -> results (row0,5), (row1,7), then done.
REQ-039 rowptr={0,0,2}, value={3,-2}, col={0,1}, x={4,6} -> row0 out_zero=1 with out_data=0; row1 out_data=0; done.
REQ-040 Hold out_ready low 10 cycles during row0 -> out_valid and out_data held stable; row1 is not emitted before the handshake.
REQ-041 SATURATE=1, DATA_W=32, ACC_W=64, three products of (2^31-1)^2 plus repeated maximum values -> result clamps at 2^63-1.
REQ-042 col[0]=9 with n_cols=4 -> err=1, busy=0 within 2 cycles, no done; the next valid start clears err.
REQ-043 Assert reset during MAC of row1 -> all outputs 0 immediately; after release with no start, no out_valid for 50 cycles.
